// File: rtl/shift_rx_pkg.sv
// shift_rx shared types and helpers.
// Parity framing is enabled by defining SHIFT_RX_PARITY_EN.
package shift_rx_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_t;

  localparam int RX_WIDTH_DEF = 4;

  function automatic int frame_len(
    input int width,
    input bit parity_en
  );
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/shift_rx_cnt.sv
// Modulo bit counter with clear, enable and terminal count.
// Clear and enable together count from zero, so a restart bit lands as bit 0.
module shift_rx_cnt #(
  parameter int CW   = 2,
  parameter int LAST = 3
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Clr,
  input  logic En,
  output logic Tc
);

  localparam logic [CW-1:0] LAST_V = CW'(LAST);

  logic [CW-1:0] cnt;
  logic [CW-1:0] base;

  assign base = Clr ? '0 : cnt;
  assign Tc   = (cnt == LAST_V);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (En) begin
      cnt <= (base == LAST_V) ? '0 : base + 1'b1;
    end else if (Clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/shift_rx.sv
// Serial-to-parallel receiver, LSB first, Valid/Ready output.
// Define SHIFT_RX_PARITY_EN for a trailing even-parity bit.
module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Shift_In,
  input  logic             Shift_En,
  input  logic             Ready,
  input  logic             Ovr_Clr,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun,
  output logic             Parity_Err
);

`ifdef SHIFT_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int FL = frame_len(WIDTH, PAR_EN);
  localparam int CW = $clog2(FL);

  rx_state_t        state;
  rx_state_t        state_nx;
  logic [WIDTH-1:0] sreg;
  logic             done;
  logic             tc;
  logic             accept;
  logic             last;
  logic             data_bit;
  logic             slot_free;

  assign accept    = Shift_En & (Start | (state == RX_RECV));
  assign last      = Shift_En & ~Start & (state == RX_RECV) & tc;
  assign data_bit  = ~(PAR_EN & tc);
  assign slot_free = ~Valid | Ready;
  assign Busy      = (state == RX_RECV);

  shift_rx_cnt #(
    .CW   (CW),
    .LAST (FL - 1)
  ) u_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clr     (Start),
    .En      (accept),
    .Tc      (tc)
  );

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      Start:   state_nx = RX_RECV;
      last:    state_nx = RX_IDLE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The parity bit (if any) is never shifted into the data word.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sreg <= '0;
    end else if (Start) begin
      sreg <= {Shift_En & Shift_In, {(WIDTH-1){1'b0}}};
    end else if (accept & data_bit) begin
      sreg <= {Shift_In, sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      done <= 1'b0;
    end else begin
      done <= last;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Data_Out <= '0;
      Valid    <= 1'b0;
    end else if (done & slot_free) begin
      Data_Out <= sreg;
      Valid    <= 1'b1;
    end else if (Valid & Ready) begin
      Valid    <= 1'b0;
    end
  end

  // A new drop outranks a same-cycle clear.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Overrun <= 1'b0;
    end else if (done & ~slot_free) begin
      Overrun <= 1'b1;
    end else if (Ovr_Clr) begin
      Overrun <= 1'b0;
    end
  end

`ifdef SHIFT_RX_PARITY_EN
  logic par_q;
  logic perr_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      par_q <= 1'b0;
    end else if (last) begin
      par_q <= Shift_In;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      perr_q <= 1'b0;
    end else if (done & slot_free) begin
      perr_q <= (^sreg) ^ par_q;
    end else if (Valid & Ready) begin
      perr_q <= 1'b0;
    end
  end

  assign Parity_Err = perr_q;
`else
  assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rx.sv
// Directed bench for shift_rx (WIDTH=4).
// Parity vectors run when SHIFT_RX_PARITY_EN is defined.
module tb_shift_rx;

`ifdef SHIFT_RX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic       Shift_In;
  logic       Shift_En;
  logic       Ready;
  logic       Ovr_Clr;
  logic [3:0] Data_Out;
  logic       Valid;
  logic       Busy;
  logic       Overrun;
  logic       Parity_Err;

  int n_cmp = 0;
  int n_mis = 0;

  shift_rx #(.WIDTH(4)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Shift_In   (Shift_In),
    .Shift_En   (Shift_En),
    .Ready      (Ready),
    .Ovr_Clr    (Ovr_Clr),
    .Data_Out   (Data_Out),
    .Valid      (Valid),
    .Busy       (Busy),
    .Overrun    (Overrun),
    .Parity_Err (Parity_Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic put_bit(input logic b);
    Shift_In = b;
    Shift_En = 1'b1;
    tick();
    Shift_En = 1'b0;
    Shift_In = 1'b0;
  endtask

  task automatic chk_out(
    input string      tag,
    input logic [3:0] d,
    input logic       v,
    input logic       o
  );
    chk({tag, ".data"}, 32'(Data_Out), 32'(d));
    chk({tag, ".valid"}, 32'(Valid), 32'(v));
    chk({tag, ".ovr"}, 32'(Overrun), 32'(o));
  endtask

  // Start, then FL bits LSB first; pbit is the parity bit when enabled.
  task automatic send(
    input logic [3:0] w,
    input logic       pbit,
    input int         gap,
    input logic       rdy
  );
    logic b;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("busy_start", 32'(Busy), 32'd1);
    for (int i = 0; i < FL; i++) begin
      b = (i < 4) ? w[i] : pbit;
      put_bit(b);
      chk("busy_bit", 32'(Busy), (i < FL - 1) ? 32'd1 : 32'd0);
      if (i < FL - 1) begin
        repeat (gap) tick();
        chk("busy_gap", 32'(Busy), 32'd1);
      end
    end
    Ready = rdy;
    tick();
    Ready = 1'b0;
  endtask

  task automatic consume();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    Reset_n  = 1'b0;
    Start    = 1'b0;
    Shift_In = 1'b0;
    Shift_En = 1'b0;
    Ready    = 1'b0;
    Ovr_Clr  = 1'b0;
    tick();
    tick();
    chk_out("rst", 4'h0, 1'b0, 1'b0);
    chk("rst.busy", 32'(Busy), 32'd0);
    chk("rst.perr", 32'(Parity_Err), 32'd0);
    Reset_n = 1'b1;
    tick();

    // Consecutive bits, word 4'hB
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("t1.busy0", 32'(Busy), 32'd1);
    put_bit(1'b1);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
`ifdef SHIFT_RX_PARITY_EN
    put_bit(1'b1);
`endif
    chk("t1.busy_end", 32'(Busy), 32'd0);
    chk("t1.pre_valid", 32'(Valid), 32'd0);
    tick();
    chk_out("t1", 4'hB, 1'b1, 1'b0);
    chk("t1.perr", 32'(Parity_Err), 32'd0);
    consume();
    chk("t1.consumed", 32'(Valid), 32'd0);

    // Gapped strobes
    send(4'h2, 1'b1, 3, 1'b0);
    chk_out("t2", 4'h2, 1'b1, 1'b0);
    consume();

    // Back-pressure drop
    send(4'hB, 1'b1, 0, 1'b0);
    chk_out("t3.first", 4'hB, 1'b1, 1'b0);
    send(4'h5, 1'b0, 0, 1'b0);
    chk_out("t3.drop", 4'hB, 1'b1, 1'b1);
    tick();
    chk("t3.sticky", 32'(Overrun), 32'd1);
    Ovr_Clr = 1'b1;
    tick();
    Ovr_Clr = 1'b0;
    chk("t3.clr", 32'(Overrun), 32'd0);

    // Consume and reload on the same edge
    send(4'h6, 1'b0, 0, 1'b1);
    chk_out("t4", 4'h6, 1'b1, 1'b0);
    consume();
    chk("t4.consumed", 32'(Valid), 32'd0);

    // Restart mid-frame
    Start = 1'b1;
    tick();
    Start = 1'b0;
    put_bit(1'b1);
    put_bit(1'b1);
    send(4'h9, 1'b0, 0, 1'b0);
    chk_out("t5.restart", 4'h9, 1'b1, 1'b0);
    consume();

    // Start with a same-cycle bit, word 4'hD
    Start    = 1'b1;
    Shift_En = 1'b1;
    Shift_In = 1'b1;
    tick();
    Start    = 1'b0;
    Shift_En = 1'b0;
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b1);
`ifdef SHIFT_RX_PARITY_EN
    put_bit(1'b1);
`endif
    tick();
    chk_out("t5.startbit", 4'hD, 1'b1, 1'b0);

    // Reset mid-frame while a word is held
    Start = 1'b1;
    tick();
    Start = 1'b0;
    put_bit(1'b0);
    put_bit(1'b1);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk_out("t5.rst", 4'h0, 1'b0, 1'b0);
    chk("t5.rst_busy", 32'(Busy), 32'd0);
    send(4'h9, 1'b0, 0, 1'b0);
    chk_out("t5.after", 4'h9, 1'b1, 1'b0);
    consume();

`ifdef SHIFT_RX_PARITY_EN
    send(4'h7, 1'b1, 0, 1'b0);
    chk_out("t6.good", 4'h7, 1'b1, 1'b0);
    chk("t6.good_perr", 32'(Parity_Err), 32'd0);
    consume();
    send(4'h7, 1'b0, 0, 1'b0);
    chk_out("t6.bad", 4'h7, 1'b1, 1'b0);
    chk("t6.bad_perr", 32'(Parity_Err), 32'd1);
    consume();
    chk("t6.perr_clr", 32'(Parity_Err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
